// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
// Shared definitions for the two-port RAM arbiter:
//   - default address/data widths matching the 8-bit single-port RAM
//   - sequencer state encodings (kept as plain constants so older code that
//     compares against raw state values keeps working)
//   - small helper used by the round-robin picker
package ram_arb_pkg;

    localparam int AW_DEFAULT = 8;
    localparam int DW_DEFAULT = 8;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // The port that should get priority after `id` has been served.
    function automatic logic other_port(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin picker. The pick itself is combinational; only the
// priority pointer is registered.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (pointer -> port 0)
//   req[1:0] in   request vector, bit k = port k
//   advance  in   the current pick is being taken; move pointer past it
//   valid    out  at least one request is present
//   winner   out  port id picked this cycle (meaningful only when valid)
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       valid,
    output logic       winner
);

    logic ptr_reg;

    assign valid = |req;

    // A lone requester wins outright; on contention the pointer decides.
    always_comb begin
        winner = 1'b0;
        if (req[0] && req[1]) begin
            winner = ptr_reg;
        end else begin
            winner = req[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= 1'b0;
        end else if (advance && valid) begin
            ptr_reg <= other_port(winner);
        end
    end

endmodule

// File: rtl/ram_arbiter_2p.sv
// ram_arbiter_2p
// Round-robin arbiter/sequencer that serialises single read/write
// transactions from two requesters onto a single-port RAM and routes read
// data back to the port that asked for it.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN, weN, addrN, wdataN requester N transaction (held until gntN)
//   gntN                     1-cycle pulse: transaction issued to the RAM
//   rvalidN                  1-cycle pulse: rdataN holds a new read result
//   rdataN                   last read result for port N
//   ram_rd, ram_wr           RAM strobes, never high together
//   ram_addr, ram_din        RAM address / write data (registered)
//   ram_dout                 RAM read data, valid the cycle after ram_rd
// Sequencing: IDLE arbitrates, ISSUE drives the RAM for one cycle, WAIT
// (reads only) lets the RAM output settle before it is captured.
module ram_arbiter_2p
    import ram_arb_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          ram_rd,
    output logic          ram_wr,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    state_t        state_reg;
    state_t        state_next;

    // Transaction latch: everything the RAM sees comes from here.
    logic          id_reg;
    logic          we_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg;

    // Read-return registers, one slot per port.
    logic [1:0]    rvalid_reg;
    logic [DW-1:0] rdata_reg [2];

    logic          arb_valid;
    logic          arb_winner;
    logic          accept;
    logic [1:0]    gnt_vec;

    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign accept = (state_reg == ST_IDLE) && arb_valid;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .req     ({req1, req0}),
        .advance (accept),
        .valid   (arb_valid),
        .winner  (arb_winner)
    );

    assign win_we    = arb_winner ? we1    : we0;
    assign win_addr  = arb_winner ? addr1  : addr0;
    assign win_wdata = arb_winner ? wdata1 : wdata0;

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (arb_valid) state_next = ST_ISSUE;
            ST_ISSUE: state_next = we_reg ? ST_IDLE : ST_WAIT;
            ST_WAIT:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Latch the winning transaction on the IDLE->ISSUE edge. addr/wdata are
    // left untouched otherwise so the RAM pins hold their last values.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_reg    <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else if (accept) begin
            id_reg    <= arb_winner;
            we_reg    <= win_we;
            addr_reg  <= win_addr;
            wdata_reg <= win_wdata;
        end
    end

    // ------------------------------------------------------------------
    // RAM side
    // ------------------------------------------------------------------
    assign ram_wr   = (state_reg == ST_ISSUE) &&  we_reg;
    assign ram_rd   = (state_reg == ST_ISSUE) && !we_reg;
    assign ram_addr = addr_reg;
    assign ram_din  = wdata_reg;

    // ------------------------------------------------------------------
    // Per-port grant and read return
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
            assign gnt_vec[gi] = (state_reg == ST_ISSUE) && (id_reg == 1'(gi));
        end
    endgenerate

    // ram_dout is valid during WAIT; capture it at the closing edge so
    // rvalid is high in the following (IDLE) cycle. A reset at that edge
    // drops the read entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_reg <= '0;
            for (int i = 0; i < 2; i++) begin
                rdata_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                rvalid_reg[i] <= (state_reg == ST_WAIT) && (id_reg == 1'(i));
                if ((state_reg == ST_WAIT) && (id_reg == 1'(i))) begin
                    rdata_reg[i] <= ram_dout;
                end
            end
        end
    end

    assign gnt0    = gnt_vec[0];
    assign gnt1    = gnt_vec[1];
    assign rvalid0 = rvalid_reg[0];
    assign rvalid1 = rvalid_reg[1];
    assign rdata0  = rdata_reg[0];
    assign rdata1  = rdata_reg[1];

endmodule

// File: tb/tb_ram_arbiter_2p.sv
module tb_ram_arbiter_2p;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic       ram_rd, ram_wr;
    logic [7:0] ram_addr, ram_din, ram_dout;

    int tests = 0;
    int fails = 0;
    int rw_both = 0;
    int ngnt, last_c, nv0, nv1;
    logic expw;
    logic got;

    // Behavioural single-port RAM: registered read, write on wr.
    logic [7:0] mem [0:255];
    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr] <= ram_din;
        if (ram_rd) ram_dout <= mem[ram_addr];
    end

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ram_rd && ram_wr) rw_both++;
    end

    ram_arbiter_2p #(.AW(8), .DW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .we0      (we0),
        .addr0    (addr0),
        .wdata0   (wdata0),
        .req1     (req1),
        .we1      (we1),
        .addr1    (addr1),
        .wdata1   (wdata1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .ram_rd   (ram_rd),
        .ram_wr   (ram_wr),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic r, input logic we,
                           input logic [7:0] a, input logic [7:0] d);
        if (p == 0) begin
            req0 = r; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = we; addr1 = a; wdata1 = d;
        end
    endtask

    function automatic logic gnt_of(input int p);
        return (p == 0) ? gnt0 : gnt1;
    endfunction

    // Write: wait (bounded) for the grant, check the RAM pins, return to IDLE.
    task automatic do_wr(input int p, input logic [7:0] a, input logic [7:0] d);
        logic seen;
        seen = 1'b0;
        set_req(p, 1'b1, 1'b1, a, d);
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            if (gnt_of(p)) seen = 1'b1;
        end
        check("wr_gnt_seen", seen, 1);
        check("wr_ram_wr", ram_wr, 1);
        check("wr_ram_rd", ram_rd, 0);
        check("wr_ram_addr", ram_addr, a);
        check("wr_ram_din", ram_din, d);
        set_req(p, 1'b0, 1'b0, 8'h00, 8'h00);
        $display("[TB] port %0d write addr %02h data %02h", p, a, d);
        tick();
        check("wr_idle_ram_wr", ram_wr, 0);
    endtask

    // Read: grant, WAIT, then rvalid with the expected data.
    task automatic do_rd(input int p, input logic [7:0] a, input logic [7:0] exp);
        logic seen;
        seen = 1'b0;
        set_req(p, 1'b1, 1'b0, a, 8'h00);
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            if (gnt_of(p)) seen = 1'b1;
        end
        check("rd_gnt_seen", seen, 1);
        check("rd_ram_rd", ram_rd, 1);
        check("rd_ram_addr", ram_addr, a);
        set_req(p, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        check("rd_wait_rvalid", (p == 0) ? rvalid0 : rvalid1, 0);
        tick();
        check("rd_rvalid", (p == 0) ? rvalid0 : rvalid1, 1);
        check("rd_rdata", (p == 0) ? rdata0 : rdata1, exp);
        $display("[TB] port %0d read addr %02h data %02h", p, a, (p == 0) ? rdata0 : rdata1);
    endtask

    initial begin
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        tick();
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_rvalid", {rvalid1, rvalid0}, 0);
        check("rst_ram_strobes", {ram_rd, ram_wr}, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_din", ram_din, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0);
        rst = 1'b0;

        // ---- Port 0 only: write 0x10=A5 then read it back ----
        set_req(0, 1'b1, 1'b1, 8'h10, 8'hA5);
        tick();                                      // cycle 1: ISSUE write
        check("p0_c1_gnt0", gnt0, 1);
        check("p0_c1_gnt1", gnt1, 0);
        check("p0_c1_ram_wr", ram_wr, 1);
        check("p0_c1_ram_addr", ram_addr, 8'h10);
        check("p0_c1_ram_din", ram_din, 8'hA5);
        $display("[TB] port 0 write addr 10 data a5");
        set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);        // new transaction: read
        tick();                                      // cycle 2: IDLE
        check("p0_c2_gnt0", gnt0, 0);
        check("p0_c2_ram_wr", ram_wr, 0);
        check("p0_c2_addr_hold", ram_addr, 8'h10);
        tick();                                      // cycle 3: ISSUE read
        check("p0_c3_gnt0", gnt0, 1);
        check("p0_c3_ram_rd", ram_rd, 1);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();                                      // cycle 4: WAIT
        check("p0_c4_rvalid0", rvalid0, 0);
        tick();                                      // cycle 5: rvalid
        check("p0_c5_rvalid0", rvalid0, 1);
        check("p0_c5_rdata0", rdata0, 8'hA5);
        $display("[TB] port 0 read addr 10 data %02h", rdata0);
        tick();
        check("p0_c6_rvalid0", rvalid0, 0);
        check("p0_c6_rdata0_hold", rdata0, 8'hA5);

        // ---- Simultaneous writes right after reset: port 0 first ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 1'b1, 1'b1, 8'h20, 8'h11);
        set_req(1, 1'b1, 1'b1, 8'h21, 8'h22);
        tick();
        check("both_gnt0_first", gnt0, 1);
        check("both_gnt1_first", gnt1, 0);
        check("both_addr_first", ram_addr, 8'h20);
        $display("[TB] port 0 write addr 20 data 11");
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        check("both_idle_gnt1", gnt1, 0);
        tick();
        check("both_gnt1_second", gnt1, 1);
        check("both_addr_second", ram_addr, 8'h21);
        check("both_din_second", ram_din, 8'h22);
        $display("[TB] port 1 write addr 21 data 22");
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        do_rd(0, 8'h20, 8'h11);
        do_rd(1, 8'h21, 8'h22);

        // ---- Continuous reads from both ports: strict alternation ----
        do_wr(0, 8'h40, 8'h4A);
        do_wr(1, 8'h41, 8'h4B);                     // ptr now back at 0
        set_req(0, 1'b1, 1'b0, 8'h40, 8'h00);
        set_req(1, 1'b1, 1'b0, 8'h41, 8'h00);
        ngnt = 0; last_c = -1; nv0 = 0; nv1 = 0; expw = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (gnt0 || gnt1) begin
                check("alt_winner", gnt1, expw);
                check("alt_onehot", gnt0 ^ gnt1, 1);
                if (last_c >= 0) check("alt_spacing", c - last_c, 3);
                $display("[TB] port %0d read addr %02h (grant %0d)", gnt1, ram_addr, ngnt);
                expw = ~expw;
                last_c = c;
                ngnt++;
                if (ngnt == 8) begin
                    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
                    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
                end
            end
            if (rvalid0) begin
                nv0++;
                check("alt_rdata0", rdata0, 8'h4A);
            end
            if (rvalid1) begin
                nv1++;
                check("alt_rdata1", rdata1, 8'h4B);
            end
        end
        check("alt_grants", ngnt, 8);
        check("alt_rvalid0_count", nv0, 4);
        check("alt_rvalid1_count", nv1, 4);

        // ---- Port 1 read vs port 0 write of 0x30 with port 1 priority ----
        do_wr(0, 8'h30, 8'h5C);                     // preload; ptr -> 1
        set_req(1, 1'b1, 1'b0, 8'h30, 8'h00);
        set_req(0, 1'b1, 1'b1, 8'h30, 8'hFF);
        tick();
        check("rw_gnt1_first", gnt1, 1);
        check("rw_gnt0_first", gnt0, 0);
        check("rw_ram_rd", ram_rd, 1);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        check("rw_wait_gnt0", gnt0, 0);
        tick();
        check("rw_rvalid1", rvalid1, 1);
        check("rw_rdata1_old", rdata1, 8'h5C);
        $display("[TB] port 1 read addr 30 data %02h", rdata1);
        check("rw_idle_gnt0", gnt0, 0);
        tick();
        check("rw_gnt0_second", gnt0, 1);
        check("rw_ram_wr", ram_wr, 1);
        check("rw_ram_din", ram_din, 8'hFF);
        $display("[TB] port 0 write addr 30 data ff");
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        do_rd(1, 8'h30, 8'hFF);

        // ---- Reset during WAIT of a port 0 read ----
        set_req(0, 1'b1, 1'b0, 8'h30, 8'h00);
        tick();
        check("rr_gnt0", gnt0, 1);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);        // ptr is now 1
        tick();                                      // WAIT
        rst = 1'b1;
        tick();
        check("rr_rvalid0", rvalid0, 0);
        check("rr_rdata0", rdata0, 0);
        check("rr_rdata1", rdata1, 0);
        $display("[TB] port 0 read addr 30 dropped by reset");
        rst = 1'b0;
        tick();
        check("rr_rvalid0_after", rvalid0, 0);

        // ---- Boundary addresses; ptr must be back at 0 ----
        set_req(0, 1'b1, 1'b1, 8'h00, 8'h00);
        set_req(1, 1'b1, 1'b1, 8'hFF, 8'hFF);
        tick();
        check("bnd_gnt0_first", gnt0, 1);
        check("bnd_addr_00", ram_addr, 8'h00);
        check("bnd_din_00", ram_din, 8'h00);
        $display("[TB] port 0 write addr 00 data 00");
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        tick();
        check("bnd_gnt1_second", gnt1, 1);
        check("bnd_addr_ff", ram_addr, 8'hFF);
        check("bnd_din_ff", ram_din, 8'hFF);
        $display("[TB] port 1 write addr ff data ff");
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        do_rd(0, 8'h00, 8'h00);
        do_rd(1, 8'hFF, 8'hFF);

        tick();
        check("never_rd_and_wr", rw_both, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_arbiter_2p.md
# ram_arbiter_2p

Two-port round-robin arbiter and sequencer for the 8-bit `single_port_RAM`. Two independent requesters each issue single read or write transactions. The block serialises them onto the RAM's `rd`/`wr`/`addr`/`d_in` pins, and returns read data to the requester that issued the read. It never asserts RAM `rd` and `wr` together, so the RAM's simultaneous read/write behaviour is never exercised through this path.

## Interface
- `AW`, default 8: address width, matches RAM `addr`.
- `DW`, default 8: data width, matches RAM `d_in`/`d_out`.

- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req0` / `req1`  in  1  transaction request from requester 0 / 1.
- `we0` / `we1`  in  1  1 = write, 0 = read; valid while `reqN`=1.
- `addr0` / `addr1`  in  AW  transaction address.
- `wdata0` / `wdata1`  in  DW  write data.
- `gnt0` / `gnt1`  out  1  one-cycle pulse: transaction accepted and issued to RAM this cycle.
- `rvalid0` / `rvalid1`  out  1  one-cycle pulse: `rdataN` holds the read result.
- `rdata0` / `rdata1`  out  DW  last read result for that port; held until that port's next read.
- `ram_rd`, `ram_wr`  out  1  to RAM `rd`, `wr`.
- `ram_addr`  out  AW  to RAM `addr`.
- `ram_din`  out  DW  to RAM `d_in`.
- `ram_dout`  in  DW  from RAM `d_out`; valid the cycle after `ram_rd` was high.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - ISSUE: drive RAM, pulse `gnt`.
  - WAIT: read only; RAM output settling.
- Transitions:
  - IDLE → ISSUE when `req0|req1`; otherwise stay in IDLE.
  - ISSUE → IDLE for a write.
  - ISSUE → WAIT for a read.
  - WAIT → IDLE always.
- Arbitration in IDLE:
  - Single requester wins outright.
  - If both request, the round-robin pointer `ptr` wins.
  - After any grant to port k, `ptr` ← other port.
  - Reset value: `ptr` = 0.
- On the IDLE→ISSUE edge:
  - Latch winner id, `we`, `addr`, `wdata` into internal registers.
  - RAM-side outputs are driven only from these registers, never combinationally from requester inputs.
- ISSUE:
  - `ram_wr` = latched `we`; `ram_rd` = !latched `we`.
  - `ram_addr` and `ram_din` = latched values.
  - `gntN` = 1 for the winner.
- WAIT: at the closing edge, `ram_dout` → `rdataN` of the latched id; `rvalidN` = 1 in the following cycle.
- Requester rules:
  - Hold `reqN` and payload stable until `gntN` is seen.
  - `reqN` still high in the cycle after `gntN` is a new transaction.
- Outside ISSUE: `ram_rd` = `ram_wr` = 0. `ram_addr` and `ram_din` hold their last values.
- Loser's request stays pending; it wins the next IDLE arbitration, since `ptr` now points at it.

## Timing
- Reset values:
  - State = IDLE, `ptr` = 0.
  - All `gnt`, `rvalid`, `ram_rd`, `ram_wr` = 0.
  - `ram_addr`, `ram_din`, `rdata0`, `rdata1` = 0.
- Write, with req sampled at edge E0:
  - `gnt` and `ram_wr` high during cycle E0..E1.
  - RAM commits at E1.
  - Back in IDLE at E1.
  - Cost: 2 cycles per write.
- Read, with req sampled at E0:
  - `gnt` and `ram_rd` high during E0..E1.
  - WAIT during E1..E2; `rdata` captured at E2.
  - `rvalid` high during E2..E3.
  - Cost: 3 cycles per read.
- `rvalid` overlaps the following IDLE cycle, so a new arbitration may occur concurrently.
- Continuous requests from both ports alternate strictly 0,1,0,1…; there is no starvation.
- Reset mid-operation:
  - `rst` high at an edge forces reset values at that edge.
  - A write whose ISSUE cycle ends at that edge still commits, because the RAM saw `wr`=1.
  - A read in ISSUE or WAIT is dropped with no `rvalid`.
  - `rdata` is cleared.
- Address wrap is the requester's concern; addresses pass through unmodified across the full 0..2^AW−1 range.

## Structure
- Shared package/header `ram_arb_pkg`:
  - State encodings `ST_IDLE`=0, `ST_ISSUE`=1, `ST_WAIT`=2.
  - Default `AW`/`DW` constants.
- Sub-module `rr_arb2`: combinational two-way round-robin picker with its registered `ptr`.
  - Inputs: `clk`, `rst`, `req[1:0]`, `advance`.
  - Outputs: `valid`, `winner`.
  - `ptr` updates on `advance`.
- Top level holds the FSM, the transaction latch, and the read-return registers.
- Verification: instantiate against the existing `single_port_RAM` behavioural model.

## Test plan
- Port 0 only: write `addr` 0x10 = 0xA5, then read 0x10 → `gnt0` on cycles 1 and 3; `rvalid0` with `rdata0`=0xA5 two cycles after the second `gnt0`; `ram_rd&ram_wr` never both 1.
- Both ports request in the same cycle after reset, port 0 writes 0x20=0x11, port 1 writes 0x21=0x22 → `gnt0` first, `gnt1` two cycles later; readback gives 0x11 / 0x22.
- Both ports hold reads continuously for 8 transactions → grants alternate 0,1,0,1…, one every 3 cycles; each `rvalidN` matches that port's address only.
- Port 1 reads 0x30 (preloaded 0x5C) while port 0 writes 0x30=0xFF, with port 1 pointer priority → `rdata1`=0x5C, then a read of 0x30 returns 0xFF.
- Assert `rst` during WAIT of a port 0 read → no `rvalid0`, `rdata0`=0; next transaction arbitrates from `ptr`=0.
- Write at addresses 0x00 and 0xFF with values 0x00 and 0xFF → both read back exactly; `ram_addr` shows no wrap artefacts.
